// File: rtl/l2_tag_ctrl_if.sv
// L1-side lookup, memory fill and tag RAM port 1 signals
// bundled for the L2 tag controller.
interface l2_tag_ctrl_if #(
  parameter int TAG_WIDTH = 7,
  parameter int IDX_WIDTH = 8
);
  localparam int AW = TAG_WIDTH + IDX_WIDTH;

  logic                 req_valid;
  logic                 req_ready;
  logic [AW-1:0]        req_addr;
  logic                 flush;
  logic                 resp_valid;
  logic                 resp_hit;
  logic                 fill_req;
  logic [AW-1:0]        fill_addr;
  logic                 fill_ack;
  logic                 tgv_we;
  logic [IDX_WIDTH-1:0] tgv_addr;
  logic [TAG_WIDTH:0]   tgv_wdata;
  logic [TAG_WIDTH:0]   tgv_rdata;

  modport master (
    output req_valid, req_addr, flush,
    output fill_ack, tgv_rdata,
    input  req_ready, resp_valid, resp_hit,
    input  fill_req, fill_addr,
    input  tgv_we, tgv_addr, tgv_wdata
  );

  modport slave (
    input  req_valid, req_addr, flush,
    input  fill_ack, tgv_rdata,
    output req_ready, resp_valid, resp_hit,
    output fill_req, fill_addr,
    output tgv_we, tgv_addr, tgv_wdata
  );
endinterface

// File: rtl/l2_tag_ctrl.sv
// L2 tag lookup/fill controller on tag RAM port 1.
// Clears the RAM after reset/flush, compares tags, fills misses.
module l2_tag_ctrl #(
  parameter int TAG_WIDTH = 7,
  parameter int IDX_WIDTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  l2_tag_ctrl_if.slave bus
);
  localparam int AW = TAG_WIDTH + IDX_WIDTH;

  typedef enum logic [2:0] {
    INIT, IDLE, RD, CMP, FILL, WR
  } state_t;

  state_t               state, state_n;
  logic [IDX_WIDTH-1:0] cnt, cnt_n;
  logic [AW-1:0]        addr_q, addr_n;

  logic                 ready_q, ready_n;
  logic                 rv_q, rv_n;
  logic                 rh_q, rh_n;
  logic                 fr_q, fr_n;
  logic [AW-1:0]        fa_q, fa_n;
  logic                 we_q, we_n;
  logic [IDX_WIDTH-1:0] ta_q, ta_n;
  logic [TAG_WIDTH:0]   wd_q, wd_n;

  logic [TAG_WIDTH-1:0] tag;
  logic [IDX_WIDTH-1:0] idx;
  logic                 hit;
  logic                 acc;

  assign tag = addr_q[AW-1:IDX_WIDTH];
  assign idx = addr_q[IDX_WIDTH-1:0];
  assign hit = bus.tgv_rdata[TAG_WIDTH]
             & (bus.tgv_rdata[TAG_WIDTH-1:0] == tag);
  assign acc = bus.req_valid & ready_q;

  // Output registers are loaded with the values the next state presents.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_q;
    ready_n = 1'b0;
    rv_n    = 1'b0;
    rh_n    = 1'b0;
    fr_n    = 1'b0;
    fa_n    = fa_q;
    we_n    = 1'b0;
    ta_n    = ta_q;
    wd_n    = wd_q;
    unique case (state)
      INIT: begin
        we_n  = 1'b1;
        ta_n  = cnt;
        wd_n  = '0;
        cnt_n = cnt + 1'b1;
        if (&cnt) state_n = IDLE;
      end
      IDLE: begin
        if (bus.flush) begin
          state_n = INIT;
          cnt_n   = '0;
        end else if (acc) begin
          addr_n  = bus.req_addr;
          ta_n    = bus.req_addr[IDX_WIDTH-1:0];
          state_n = RD;
        end else begin
          ready_n = 1'b1;
        end
      end
      RD: state_n = CMP;
      CMP: begin
        if (hit) begin
          state_n = IDLE;
          rv_n    = 1'b1;
          rh_n    = 1'b1;
          ready_n = 1'b1;
        end else begin
          state_n = FILL;
          fr_n    = 1'b1;
          fa_n    = addr_q;
        end
      end
      FILL: begin
        if (fr_q & bus.fill_ack) begin
          state_n = WR;
          we_n    = 1'b1;
          ta_n    = idx;
          wd_n    = {1'b1, tag};
        end else begin
          fr_n = 1'b1;
        end
      end
      WR: begin
        state_n = IDLE;
        rv_n    = 1'b1;
        ready_n = 1'b1;
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      cnt     <= '0;
      addr_q  <= '0;
      ready_q <= 1'b0;
      rv_q    <= 1'b0;
      rh_q    <= 1'b0;
      fr_q    <= 1'b0;
      fa_q    <= '0;
      we_q    <= 1'b0;
      ta_q    <= '0;
      wd_q    <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      addr_q  <= addr_n;
      ready_q <= ready_n;
      rv_q    <= rv_n;
      rh_q    <= rh_n;
      fr_q    <= fr_n;
      fa_q    <= fa_n;
      we_q    <= we_n;
      ta_q    <= ta_n;
      wd_q    <= wd_n;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = rv_q;
  assign bus.resp_hit   = rh_q;
  assign bus.fill_req   = fr_q;
  assign bus.fill_addr  = fa_q;
  assign bus.tgv_we     = we_q;
  assign bus.tgv_addr   = ta_q;
  assign bus.tgv_wdata  = wd_q;
endmodule
